// File: rtl/maxpool_layer1.sv
// maxpool_layer1: 2x2 stride-2 max-pooling over each layer-0 feature map.
// Reads four pixels per window, keeps a running unsigned max and writes one
// pooled pixel per window back through the shared result-memory port.
module maxpool_layer1 #(
    parameter int IMG_W  = 64,
    parameter int DW     = 20,
    parameter int AW     = 12,
    parameter int NUM_CH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam int OW = IMG_W / 2;
    localparam int PW = (OW > 1) ? $clog2(OW) : 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [PW-1:0] PosLast = PW'(OW - 1);
    localparam logic [CW-1:0] ChLast  = CW'(NUM_CH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLast,
        StWrite,
        StNext,
        StDone
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   ch_q;
    logic [PW-1:0]   prow_q;
    logic [PW-1:0]   pcol_q;
    logic [1:0]      k_q;
    logic [DW-1:0]   max_q;

    logic [DW-1:0]   max_upd;
    logic            col_wrap;
    logic            win_last;
    logic [PW-1:0]   nxt_prow;
    logic [PW-1:0]   nxt_pcol;
    logic [CW-1:0]   nxt_ch;

    // Input-map address of pixel k within window (r, c); k[1] picks the row, k[0] the column.
    function automatic logic [AW-1:0] rd_addr(input logic [PW-1:0] r, input logic [PW-1:0] c,
                                              input logic [1:0] k);
        logic [AW-1:0] row;
        logic [AW-1:0] col;
        row = AW'({r, k[1]});
        col = AW'({c, k[0]});
        return AW'(row * AW'(IMG_W)) + col;
    endfunction

    // Pooled-map address of window (r, c).
    function automatic logic [AW-1:0] wr_addr(input logic [PW-1:0] r, input logic [PW-1:0] c);
        return AW'(AW'(r) * AW'(OW)) + AW'(c);
    endfunction

    // Layer-0 banks start at 3'b001, layer-1 banks at 3'b011.
    function automatic logic [2:0] rd_sel(input logic [CW-1:0] c);
        return 3'd1 + 3'(c);
    endfunction

    function automatic logic [2:0] wr_sel(input logic [CW-1:0] c);
        return 3'd3 + 3'(c);
    endfunction

    // Running-max candidate and next-window stepping.
    always_comb begin
        max_upd  = (cdata_rd > max_q) ? cdata_rd : max_q;
        col_wrap = (pcol_q == PosLast);
        win_last = col_wrap && (prow_q == PosLast);
        nxt_pcol = col_wrap ? '0 : pcol_q + PW'(1);
        nxt_prow = col_wrap ? prow_q + PW'(1) : prow_q;
        nxt_ch   = ch_q + CW'(1);
    end

    // Control FSM; every port output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            prow_q   <= '0;
            pcol_q   <= '0;
            k_q      <= '0;
            max_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            csel     <= 3'b000;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q  <= StRead;
                        ch_q     <= '0;
                        prow_q   <= '0;
                        pcol_q   <= '0;
                        k_q      <= '0;
                        busy     <= 1'b1;
                        crd      <= 1'b1;
                        csel     <= rd_sel('0);
                        caddr_rd <= rd_addr('0, '0, 2'd0);
                    end
                end
                StRead: begin
                    // Data lags the read by one cycle: k=1 sees pixel 0, which seeds the max.
                    if (k_q == 2'd1) begin
                        max_q <= cdata_rd;
                    end else if (k_q != 2'd0) begin
                        max_q <= max_upd;
                    end
                    if (k_q == 2'd3) begin
                        state_q <= StLast;
                        crd     <= 1'b0;
                    end else begin
                        k_q      <= k_q + 2'd1;
                        caddr_rd <= rd_addr(prow_q, pcol_q, k_q + 2'd1);
                    end
                end
                StLast: begin
                    // Fourth pixel folds straight into the write data.
                    state_q  <= StWrite;
                    cwr      <= 1'b1;
                    csel     <= wr_sel(ch_q);
                    caddr_wr <= wr_addr(prow_q, pcol_q);
                    cdata_wr <= max_upd;
                end
                StWrite: begin
                    cwr <= 1'b0;
                    if (win_last) begin
                        state_q <= StNext;
                        csel    <= 3'b000;
                    end else begin
                        state_q  <= StRead;
                        prow_q   <= nxt_prow;
                        pcol_q   <= nxt_pcol;
                        k_q      <= '0;
                        crd      <= 1'b1;
                        csel     <= rd_sel(ch_q);
                        caddr_rd <= rd_addr(nxt_prow, nxt_pcol, 2'd0);
                    end
                end
                StNext: begin
                    prow_q <= '0;
                    pcol_q <= '0;
                    if (ch_q != ChLast) begin
                        state_q  <= StRead;
                        ch_q     <= nxt_ch;
                        k_q      <= '0;
                        crd      <= 1'b1;
                        csel     <= rd_sel(nxt_ch);
                        caddr_rd <= rd_addr('0, '0, 2'd0);
                    end else begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
